// File: rtl/hsv_core_flush_ctrl_if.sv
// Flush controller bus: commit trigger, per-unit flush handshake, fetch redirect
// channel and status. The controller side uses the master modport.
interface hsv_core_flush_ctrl_if #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned CNT_WIDTH = 16
);
    // Commit -> controller trigger channel
    logic                 trigger_valid;
    logic [31:0]          trigger_pc;
    logic                 trigger_ready;

    // Controller <-> execution units
    logic [NUM_UNITS-1:0] flush_req;
    logic [NUM_UNITS-1:0] flush_ack;

    // Controller -> fetch restart channel
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 redirect_ready;

    // Status and error handling
    logic                 busy;
    logic                 timeout_err;
    logic                 err_clr;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        input  trigger_valid,
        input  trigger_pc,
        output trigger_ready,
        output flush_req,
        input  flush_ack,
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready,
        output busy,
        output timeout_err,
        input  err_clr,
        output flush_count
    );

    modport slave (
        output trigger_valid,
        output trigger_pc,
        input  trigger_ready,
        input  flush_req,
        output flush_ack,
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready,
        input  busy,
        input  timeout_err,
        output err_clr,
        input  flush_count
    );
endinterface

// File: rtl/hsv_core_flush_ctrl.sv
// Pipeline flush sequencer: accepts a redirect trigger from commit, raises
// flush_req on every execution unit until all have acknowledged (or a timeout
// expires), then hands the latched restart PC to fetch over valid/ready.
// ACK_TIMEOUT must be at least 2.
module hsv_core_flush_ctrl #(
    parameter int unsigned NUM_UNITS   = 4,
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    hsv_core_flush_ctrl_if.master bus
);

    localparam int unsigned          TMO_W     = $clog2(ACK_TIMEOUT);
    // Counter value during the last FLUSH cycle allowed before forcing redirect
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [NUM_UNITS-1:0] ALL_UNITS = {NUM_UNITS{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedirect
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [31:0]          r_pc;
    logic [31:0]          w_pc_next;
    logic [NUM_UNITS-1:0] r_acked;
    logic [NUM_UNITS-1:0] w_acked_next;
    logic [TMO_W-1:0]     r_tmo;
    logic [TMO_W-1:0]     w_tmo_next;
    logic                 r_timeout_err;
    logic                 w_timeout_err_next;
    logic [CNT_WIDTH-1:0] r_flush_count;
    logic [CNT_WIDTH-1:0] w_flush_count_next;

    logic w_accept;
    logic w_all_acked;
    logic w_complete;
    logic w_tmo_hit;
    logic w_redirect_done;

    // Event decode shared by the FSM and the datapath
    always_comb begin
        w_accept        = bus.trigger_valid && (r_state == StIdle);
        // Acks are sticky: a unit may drop its ack before the others arrive
        w_all_acked     = ((r_acked | bus.flush_ack) == ALL_UNITS);
        w_complete      = (r_state == StFlush) && w_all_acked;
        // Completion on the final cycle takes priority over the timeout
        w_tmo_hit       = (r_state == StFlush) && (r_tmo == TMO_LAST) && !w_all_acked;
        w_redirect_done = (r_state == StRedirect) && bus.redirect_ready;
    end

    // FSM state register
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StFlush;
                end
            end
            StFlush: begin
                if (w_complete || w_tmo_hit) begin
                    w_state_next = StRedirect;
                end
            end
            StRedirect: begin
                if (bus.redirect_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs, decoded from the state register only
    always_comb begin
        bus.trigger_ready  = (r_state == StIdle);
        bus.flush_req      = (r_state == StFlush) ? ALL_UNITS : '0;
        bus.redirect_valid = (r_state == StRedirect);
        bus.busy           = (r_state != StIdle);
        bus.redirect_pc    = r_pc;
        bus.timeout_err    = r_timeout_err;
        bus.flush_count    = r_flush_count;
    end

    // Datapath next-state: PC latch, ack mask, timeout counter, error, statistics
    always_comb begin
        w_pc_next          = r_pc;
        w_acked_next       = r_acked;
        w_tmo_next         = r_tmo;
        w_timeout_err_next = r_timeout_err;
        w_flush_count_next = r_flush_count;

        if (w_accept) begin
            w_pc_next    = bus.trigger_pc;
            w_acked_next = '0;
            w_tmo_next   = '0;
        end else if (r_state == StFlush) begin
            w_acked_next = r_acked | bus.flush_ack;
            w_tmo_next   = r_tmo + TMO_W'(1);
        end

        // A new timeout overrides a simultaneous clear
        if (w_tmo_hit) begin
            w_timeout_err_next = 1'b1;
        end else if (bus.err_clr) begin
            w_timeout_err_next = 1'b0;
        end

        if (w_redirect_done) begin
            w_flush_count_next = r_flush_count + CNT_WIDTH'(1);
        end
    end

    // Datapath registers; reset discards any pending restart PC
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            r_pc          <= '0;
            r_acked       <= '0;
            r_tmo         <= '0;
            r_timeout_err <= 1'b0;
            r_flush_count <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_acked       <= w_acked_next;
            r_tmo         <= w_tmo_next;
            r_timeout_err <= w_timeout_err_next;
            r_flush_count <= w_flush_count_next;
        end
    end

endmodule

// File: doc/hsv_core_flush_ctrl.md
Name: hsv_core_flush_ctrl

Overview:
Pipeline flush sequencer for the execution back end. It accepts a redirect trigger (branch mispredict or exception) from commit and broadcasts flush_req to every execution unit: branch, ALU, memory, and others. It collects each unit's flush_ack, then hands the restart PC to fetch over a valid/ready channel. It is the single owner of every unit's flush_req input.

Parameters:
NUM_UNITS, 4, number of execution units driven; bit i of flush_req/flush_ack belongs to unit i
ACK_TIMEOUT, 15, maximum FLUSH-state cycles waited for acks before forcing redirect; must be >= 2
CNT_WIDTH, 16, width of the wrapping flush statistics counter

Ports:
clk_core  in  1  core clock
rst_core  in  1  asynchronous active-high reset
trigger_valid  in  1  commit requests a flush/redirect
trigger_pc  in  32  restart PC, sampled on trigger handshake
trigger_ready  out  1  controller can accept a trigger
flush_req  out  NUM_UNITS  per-unit flush request
flush_ack  in  NUM_UNITS  per-unit flush acknowledge
redirect_valid  out  1  restart PC available to fetch
redirect_pc  out  32  restart PC
redirect_ready  in  1  fetch accepts redirect
busy  out  1  state != IDLE
timeout_err  out  1  sticky: some unit failed to ack within ACK_TIMEOUT
err_clr  in  1  clears timeout_err
flush_count  out  CNT_WIDTH  number of completed flush sequences, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, immediate):
  - state=IDLE; flush_req=0, redirect_valid=0, redirect_pc=0, timeout_err=0, flush_count=0.
  - acked mask=0, timeout counter=0; trigger_ready=1 once reset releases.
  - Reset mid-sequence drops flush_req and redirect_valid at once; the pending PC is discarded.
- States: IDLE, FLUSH, REDIRECT.
- trigger_ready = (state==IDLE), combinational from the state register only.
- IDLE:
  - On trigger_valid&trigger_ready at edge T: latch trigger_pc into redirect_pc, clear the acked mask and timeout counter, and enter FLUSH.
  - flush_req = all ones from T+1.
- FLUSH:
  - flush_req is all ones and registered; it is held for the whole state even after individual acks.
  - acked mask |= flush_ack every cycle; acks are sticky, so a unit may drop its ack early.
  - Completion condition: (acked | flush_ack) == all ones. On that edge go to REDIRECT: flush_req=0 and redirect_valid=1 from the next cycle.
  - Timeout counter increments each FLUSH cycle. On the edge where it equals ACK_TIMEOUT-1 without completion: set timeout_err and go to REDIRECT anyway.
  - If completion and timeout happen on the same edge, completion wins and timeout_err is not set.
- REDIRECT:
  - redirect_valid=1 and redirect_pc is stable until the handshake.
  - On redirect_valid&redirect_ready: enter IDLE, increment flush_count (wrap to 0 after all ones), and drop redirect_valid next cycle.
- Triggers are never accepted in FLUSH or REDIRECT; the source holds trigger_valid/trigger_pc.
- The earliest next acceptance is the cycle after the redirect handshake, so the minimum spacing is 1 idle cycle.
- Latency with units that ack one cycle after flush_req:
  - trigger accepted at T, flush_req high T+1..T+2.
  - redirect_valid high T+3; minimum trigger-to-redirect is 3 cycles.
- timeout_err: if err_clr and a new timeout happen on the same edge, set wins. err_clr in any state otherwise clears it.
- flush_ack bits seen in IDLE or REDIRECT are ignored.

Test Plan:
- Reset then trigger_pc=0x0000_1000, all 4 units ack 1 cycle after flush_req, redirect_ready=1 -> flush_req=4'b1111 for 2 cycles, redirect_valid at T+3 with pc 0x1000, flush_count=1, busy low at T+4.
- Staggered acks: unit0 at T+2 (single-cycle pulse), unit3 at T+5, others at T+3 -> flush_req held to T+5, redirect_valid at T+6, timeout_err=0.
- Unit2 never acks, ACK_TIMEOUT=15 -> flush_req high exactly 15 cycles, then redirect_valid with the latched PC and timeout_err=1. err_clr pulse later -> timeout_err=0.
- Second trigger (pc 0x2000) asserted during FLUSH, redirect_ready held 0 for 4 cycles -> trigger_ready=0 throughout, redirect_pc stays 0x1000. The second trigger is accepted the cycle after the redirect handshake and then redirected to 0x2000.
- Assert rst_core mid-FLUSH and mid-REDIRECT -> flush_req, redirect_valid, flush_count, timeout_err are 0 immediately; trigger_ready=1 after release.
- 65536 back-to-back completed flushes with CNT_WIDTH=16 -> flush_count wraps 0xFFFF→0x0000.
